// File: rtl/rggen_bus_initiator_if.sv
// rggen_bus_if: request/response wires between a bus initiator (master)
// and a register-block bus adapter (slave), plus the shared status type.

package rggen_bus_pkg;
    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;
endpackage

interface rggen_bus_if
    import rggen_bus_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                     valid;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     write;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     ready;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid, address, write, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, address, write, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_bus_initiator.sv
// rggen_bus_initiator: single-outstanding command -> rggen_bus_if transfer
// -> response bridge. Optional timeout/drain logic is enabled by defining
// RGGEN_BUS_INITIATOR_TIMEOUT_EN.

module rggen_bus_initiator
    import rggen_bus_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
)(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
    input  logic                     i_cmd_write,
    input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output rggen_status              o_rsp_status,
    output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
    output logic                     o_busy,
    rggen_bus_if.master              bus_if
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RSP   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                   state_reg;
    state_t                   state_next;

    logic                     valid_reg;
    logic [ADDRESS_WIDTH-1:0] address_reg;
    logic                     write_reg;
    logic [BUS_WIDTH-1:0]     write_data_reg;
    logic [BUS_WIDTH/8-1:0]   strobe_reg;
    logic                     rsp_valid_reg;
    rggen_status              rsp_status_reg;
    logic [BUS_WIDTH-1:0]     rsp_read_data_reg;
    logic                     timeout_hit;

`ifdef RGGEN_BUS_INITIATOR_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count_reg;
    logic             timed_out_reg;

    assign timeout_hit = (state_reg == BUS) && !bus_if.ready &&
                         (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // Timeout counter: zero outside BUS, counts BUS cycles without ready;
    // timed_out_reg remembers that the pending response is a timeout error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg     <= '0;
            timed_out_reg <= 1'b0;
        end else begin
            if (state_reg != BUS) begin
                count_reg <= '0;
            end else if (!bus_if.ready) begin
                count_reg <= count_reg + 1'b1;
            end
            if (timeout_hit) begin
                timed_out_reg <= 1'b1;
            end else if (state_reg == IDLE) begin
                timed_out_reg <= 1'b0;
            end
        end
    end
`else
    // Keeps the parameter referenced when the timeout logic is compiled out.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_cmd_valid) state_next = BUS;
            end
            BUS: begin
                if (bus_if.ready || timeout_hit) state_next = RSP;
            end
            RSP: begin
                if (i_rsp_ready) begin
`ifdef RGGEN_BUS_INITIATOR_TIMEOUT_EN
                    state_next = timed_out_reg ? DRAIN : IDLE;
`else
                    state_next = IDLE;
`endif
                end
            end
            DRAIN: begin
                // The abandoned transfer's late ready is swallowed here.
                if (bus_if.ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered bus request and response outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_reg         <= 1'b0;
            address_reg       <= '0;
            write_reg         <= 1'b0;
            write_data_reg    <= '0;
            strobe_reg        <= '0;
            rsp_valid_reg     <= 1'b0;
            rsp_status_reg    <= RGGEN_OKAY;
            rsp_read_data_reg <= '0;
        end else begin
            valid_reg     <= (state_next == BUS);
            rsp_valid_reg <= (state_next == RSP);
            if (state_reg == IDLE && i_cmd_valid) begin
                address_reg    <= i_cmd_address;
                write_reg      <= i_cmd_write;
                write_data_reg <= i_cmd_write_data;
                strobe_reg     <= i_cmd_strobe;
            end
            if (state_reg == BUS && bus_if.ready) begin
                rsp_status_reg    <= bus_if.status;
                rsp_read_data_reg <= write_reg ? '0 : bus_if.read_data;
            end else if (timeout_hit) begin
                rsp_status_reg    <= RGGEN_SLAVE_ERROR;
                rsp_read_data_reg <= '0;
            end
        end
    end

    // State-decoded outputs and port wiring.
    always_comb begin
        o_cmd_ready = (state_reg == IDLE);
        o_busy      = (state_reg != IDLE);
    end

    assign bus_if.valid      = valid_reg;
    assign bus_if.address    = address_reg;
    assign bus_if.write      = write_reg;
    assign bus_if.write_data = write_data_reg;
    assign bus_if.strobe     = strobe_reg;
    assign o_rsp_valid       = rsp_valid_reg;
    assign o_rsp_status      = rsp_status_reg;
    assign o_rsp_read_data   = rsp_read_data_reg;

endmodule
